// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default width.
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit full-adder cell; the only arithmetic in the serial adder datapath.
module serial_adder_full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell with a registered carry.
// Optional signed-overflow output Ovf is built when SERIAL_ADDER_OVERFLOW_EN is defined.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
`ifdef SERIAL_ADDER_OVERFLOW_EN
  output logic             Ovf,
`endif
  output state_t           dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  // Handshake: an accepted start is start=1 sampled in IDLE or DONE; the result
  // is valid for the single cycle done is high and is held until the next accepted start.
  state_t           state;
  logic [WIDTH-1:0] opa, opb, sum_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             fa_s, fa_co;
  logic [WIDTH-1:0] sum_next;

  serial_adder_full_adder u_fa (
    .a  (opa[0]),
    .b  (opb[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign sum_next  = {fa_s, sum_sr[WIDTH-1:1]};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      Sum    <= '0;
      Cout   <= 1'b0;
      opa    <= '0;
      opb    <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
`ifdef SERIAL_ADDER_OVERFLOW_EN
      Ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            opa    <= A;
            opb    <= B;
            carry  <= Cin;
            cnt    <= '0;
            sum_sr <= '0;
            busy   <= 1'b1;
            state  <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SHIFT: begin
          sum_sr <= sum_next;
          carry  <= fa_co;
          opa    <= opa >> 1;
          opb    <= opb >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            // On the MSB step, carry still holds the carry into the MSB.
            Sum   <= sum_next;
            Cout  <= fa_co;
`ifdef SERIAL_ADDER_OVERFLOW_EN
            Ovf   <= carry ^ fa_co;
`endif
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8, checked with immediate assertions.
module tb_serial_adder;
  import serial_adder_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         Cin = 1'b0;
  logic         busy, done, Cout;
  logic [W-1:0] Sum;
  state_t       dbg_state;
`ifdef SERIAL_ADDER_OVERFLOW_EN
  logic         Ovf;
`endif

  int passed = 0;
  int total  = 0;
  logic [W-1:0] last_sum = '0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .A         (A),
    .B         (B),
    .Cin       (Cin),
    .busy      (busy),
    .done      (done),
    .Sum       (Sum),
    .Cout      (Cout),
`ifdef SERIAL_ADDER_OVERFLOW_EN
    .Ovf       (Ovf),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drives one op from IDLE/DONE at a negedge, walks the 8 busy cycles, checks the result.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W-1:0] es, input logic ec, input logic eo);
    int busy_cnt = 0;
    int held = 1;
    A = a; B = b; Cin = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (busy === 1'b1 && done === 1'b0) busy_cnt++;
      if (Sum !== last_sum) held = 0;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, busy_cnt, W);
    check({tag, "_sum_held"}, held, 1);
    check({tag, "_done"}, {busy, done}, 2'b01);
    check({tag, "_sum"}, Sum, es);
    check({tag, "_cout"}, Cout, ec);
`ifdef SERIAL_ADDER_OVERFLOW_EN
    check({tag, "_ovf"}, Ovf, eo);
`else
    if (eo === 1'bx) check({tag, "_ovf_arg"}, 0, 1);
`endif
    last_sum = es;
    @(negedge clk);
    check({tag, "_after"}, {busy, done, dbg_state}, {2'b00, IDLE});
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_outs", {busy, done, Sum, Cout}, '0);
    check("reset_state", dbg_state, IDLE);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_start", {busy, done, dbg_state}, {2'b00, IDLE});

    run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    run_op("add_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);

    // start during SHIFT must be ignored
    A = 8'h12; B = 8'h34; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("ign_busy4", busy, 1'b1);
    A = 8'h01; B = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("ign_done", {busy, done}, 2'b01);
    check("ign_sum", {Cout, Sum}, {1'b0, 8'h46});
    @(negedge clk);
    check("ign_after", {busy, done}, 2'b00);

    // reset on the 5th busy cycle discards the op and clears the result
    A = 8'hAA; B = 8'h55; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_busy5", busy, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_outs", {busy, done, Cout, Sum}, '0);
    check("rst_state", dbg_state, IDLE);
    rst_n = 1'b1;
    repeat (W + 2) @(negedge clk);
    check("rst_no_done", {busy, done, dbg_state}, {2'b00, IDLE});
    last_sum = '0;

    // back-to-back: start high while in DONE
    A = 8'h01; B = 8'h02; Cin = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (W) @(negedge clk);
    check("b2b_first_done", {done, Sum}, {1'b1, 8'h04});
    A = 8'h10; B = 8'h20; Cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("b2b_rebusy", {busy, done, dbg_state}, {2'b10, SHIFT});
    check("b2b_sum_hold", Sum, 8'h04);
    repeat (W) @(negedge clk);
    check("b2b_second_done", {busy, done, Cout, Sum}, {2'b01, 1'b0, 8'h30});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
